// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the mux round-robin scheduler: state encodings,
// requester count, select width and a select-to-one-hot helper.
package mux_rr_scheduler_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } sched_state_t;

   // One-hot image of a mux select value
   function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
      return NUM_REQ'(1) << s;
   endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Request/grant bundle between the requesters and the mux scheduler.
// master: requester side (drives req), slave: scheduler side.
interface mux_rr_scheduler_if;
   import mux_rr_scheduler_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [SEL_W-1:0]   sel;
   logic               en;
   logic [NUM_REQ-1:0] grant;
   logic               busy;
   logic               slot_done;

   modport master (output req, input sel, en, grant, busy, slot_done);
   modport slave  (input req, output sel, en, grant, busy, slot_done);
endinterface

// File: rtl/mux_rr_scheduler_rr_pick4.sv
// Combinational 4-way round-robin picker: searches req starting one past
// ptr, wrapping around, and returns the first set index.
module rr_pick4
   import mux_rr_scheduler_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               valid,
   output logic [SEL_W-1:0]   idx
);

   // rot[k] is the request at search position k (position 0 = ptr+1)
   logic [NUM_REQ-1:0] rot;
   logic [SEL_W-1:0]   off;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         logic [SEL_W-1:0] pos;
         assign pos     = ptr + SEL_W'(gi + 1);
         assign rot[gi] = req[pos];
      end
   endgenerate

   // Lowest search position with a request wins; index wraps modulo 4
   always_comb begin
      valid = |req;
      off   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = SEL_W'(k);
      end
      idx = ptr + SEL_W'(1) + off;
   end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a shared 4:1 mux. Each requester holds the mux for
// at most SLOT_LEN cycles and loses it early once it drops its request.
// Optional macro MUX_SCHED_GAP_EN inserts one dead cycle between grants;
// without it, grants run back to back.
module mux_rr_scheduler
   import mux_rr_scheduler_pkg::*;
#(
   parameter int SLOT_LEN = 4,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   mux_rr_scheduler_if.slave   bus
);

   localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_LEN - 1);

   sched_state_t       state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [SEL_W-1:0]   ptr_reg;
   logic [SEL_W-1:0]   sel_reg;
   logic               en_reg;
   logic [NUM_REQ-1:0] grant_reg;
   logic               busy_reg;
   logic               slot_done_reg;

   logic [SEL_W-1:0]   pick_ptr;
   logic               pick_valid;
   logic [SEL_W-1:0]   pick_idx;
   logic               slot_end;

   // A pick at slot end rotates from the outgoing owner; otherwise from
   // the stored last-grant pointer
   assign pick_ptr = (state_reg == ST_GRANT) ? sel_reg : ptr_reg;

   // Slot ends on expiry or when the current owner withdraws
   assign slot_end = (cnt_reg == '0) || !bus.req[sel_reg];

   rr_pick4 u_pick (
      .req   (bus.req),
      .ptr   (pick_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Scheduler FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         ptr_reg       <= SEL_W'(NUM_REQ - 1);
         sel_reg       <= '0;
         en_reg        <= 1'b0;
         grant_reg     <= '0;
         busy_reg      <= 1'b0;
         slot_done_reg <= 1'b0;
      end else begin
         slot_done_reg <= 1'b0;
         case (state_reg)
            ST_GRANT: begin
               if (slot_end) begin
                  ptr_reg       <= sel_reg;
                  slot_done_reg <= 1'b1;
`ifdef MUX_SCHED_GAP_EN
                  state_reg <= ST_GAP;
                  en_reg    <= 1'b0;
                  grant_reg <= '0;
                  busy_reg  <= 1'b1;
`else
                  if (pick_valid) begin
                     state_reg <= ST_GRANT;
                     sel_reg   <= pick_idx;
                     en_reg    <= 1'b1;
                     grant_reg <= sel_onehot(pick_idx);
                     cnt_reg   <= SLOT_LOAD;
                     busy_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_IDLE;
                     en_reg    <= 1'b0;
                     grant_reg <= '0;
                     busy_reg  <= 1'b0;
                  end
`endif
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            default: begin
               // IDLE, and GAP after its single dead cycle
               if (pick_valid) begin
                  state_reg <= ST_GRANT;
                  sel_reg   <= pick_idx;
                  en_reg    <= 1'b1;
                  grant_reg <= sel_onehot(pick_idx);
                  cnt_reg   <= SLOT_LOAD;
                  busy_reg  <= 1'b1;
               end else begin
                  state_reg <= ST_IDLE;
                  en_reg    <= 1'b0;
                  grant_reg <= '0;
                  busy_reg  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.sel       = sel_reg;
   assign bus.en        = en_reg;
   assign bus.grant     = grant_reg;
   assign bus.busy      = busy_reg;
   assign bus.slot_done = slot_done_reg;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler in its default (back-to-back) build
// with SLOT_LEN=4.
module tb_mux_rr_scheduler;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mux_rr_scheduler_if bus ();

   mux_rr_scheduler #(.SLOT_LEN(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = 4'b0000;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus.req = 4'b1111;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (bus.en !== 1'b0 || bus.grant !== 4'b0000 || bus.sel !== 2'b00 ||
             bus.busy !== 1'b0 || bus.slot_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold c=%0d: en=%b grant=%b sel=%0d busy=%b done=%b, want all zero",
                     c, bus.en, bus.grant, bus.sel, bus.busy, bus.slot_done);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.en !== 1'b1 || bus.busy !== 1'b1 || bus.sel !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_grant: grant=%b en=%b busy=%b sel=%0d, want 0001 1 1 0",
                  bus.grant, bus.en, bus.busy, bus.sel);
      end
      $display("test_reset done: grant=%b", bus.grant);
   endtask

   // Continues directly from test_reset: requester 0 is in its first slot cycle
   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      for (int s = 0; s < 5; s++) begin
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.grant !== exp_g[s] || bus.en !== 1'b1) begin
               errors++;
               $display("FAIL rr_grant s=%0d c=%0d: grant=%b en=%b, want %b 1",
                        s, c, bus.grant, bus.en, exp_g[s]);
            end
            checks++;
            if (bus.slot_done !== ((c == 0) && (s > 0))) begin
               errors++;
               $display("FAIL rr_slot_done s=%0d c=%0d: got %b want %b",
                        s, c, bus.slot_done, (c == 0) && (s > 0));
            end
            tick();
         end
         $display("test_round_robin slot %0d: grant=%b", s, exp_g[s]);
      end
   endtask

   task automatic test_sole_requester();
      do_reset();
      bus.req = 4'b0100;
      tick();
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (bus.grant !== 4'b0100 || bus.en !== 1'b1 || bus.sel !== 2'd2) begin
            errors++;
            $display("FAIL sole_grant k=%0d: grant=%b en=%b sel=%0d, want 0100 1 2",
                     k, bus.grant, bus.en, bus.sel);
         end
         checks++;
         if (bus.slot_done !== ((k % 4 == 0) && (k > 0))) begin
            errors++;
            $display("FAIL sole_slot_done k=%0d: got %b want %b",
                     k, bus.slot_done, (k % 4 == 0) && (k > 0));
         end
         tick();
      end
      $display("test_sole_requester done: grant=%b", bus.grant);
   endtask

   task automatic test_early_release();
      do_reset();
      bus.req = 4'b0101;
      tick();
      checks++;
      if (bus.grant !== 4'b0001) begin
         errors++;
         $display("FAIL early_first: grant=%b want 0001", bus.grant);
      end
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.slot_done !== 1'b0) begin
         errors++;
         $display("FAIL early_cycle2: grant=%b done=%b want 0001 0", bus.grant, bus.slot_done);
      end
      bus.req = 4'b0100;
      tick();
      checks++;
      if (bus.grant !== 4'b0100 || bus.sel !== 2'd2 || bus.slot_done !== 1'b1 || bus.en !== 1'b1) begin
         errors++;
         $display("FAIL early_handover: grant=%b sel=%0d done=%b en=%b want 0100 2 1 1",
                  bus.grant, bus.sel, bus.slot_done, bus.en);
      end
      tick();
      checks++;
      if (bus.slot_done !== 1'b0 || bus.grant !== 4'b0100) begin
         errors++;
         $display("FAIL early_pulse_width: done=%b grant=%b want 0 0100", bus.slot_done, bus.grant);
      end
      bus.req = 4'b0000;
      tick();
      checks++;
      if (bus.en !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0 ||
          bus.slot_done !== 1'b1 || bus.sel !== 2'd2) begin
         errors++;
         $display("FAIL early_to_idle: en=%b grant=%b busy=%b done=%b sel=%0d want 0 0000 0 1 2",
                  bus.en, bus.grant, bus.busy, bus.slot_done, bus.sel);
      end
      tick();
      checks++;
      if (bus.en !== 1'b0 || bus.slot_done !== 1'b0 || bus.sel !== 2'd2) begin
         errors++;
         $display("FAIL idle_hold: en=%b done=%b sel=%0d want 0 0 2", bus.en, bus.slot_done, bus.sel);
      end
      $display("test_early_release done");
   endtask

   task automatic test_rotation_skip();
      do_reset();
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (bus.grant !== 4'b0010) begin
            errors++;
            $display("FAIL rot_first c=%0d: grant=%b want 0010", c, bus.grant);
         end
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (bus.grant !== 4'b1000 || bus.slot_done !== (c == 0)) begin
            errors++;
            $display("FAIL rot_skip c=%0d: grant=%b done=%b want 1000 %b",
                     c, bus.grant, bus.slot_done, c == 0);
         end
         tick();
      end
      checks++;
      if (bus.grant !== 4'b0010 || bus.slot_done !== 1'b1) begin
         errors++;
         $display("FAIL rot_wrap: grant=%b done=%b want 0010 1", bus.grant, bus.slot_done);
      end
      $display("test_rotation_skip done: grant=%b", bus.grant);
   endtask

   task automatic test_reset_mid_slot();
      do_reset();
      bus.req = 4'b0100;
      tick();
      tick();
      checks++;
      if (bus.grant !== 4'b0100) begin
         errors++;
         $display("FAIL mid_setup: grant=%b want 0100", bus.grant);
      end
      rst     = 1'b1;
      bus.req = 4'b1111;
      tick();
      checks++;
      if (bus.en !== 1'b0 || bus.grant !== 4'b0000 || bus.sel !== 2'd0 ||
          bus.busy !== 1'b0 || bus.slot_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: en=%b grant=%b sel=%0d busy=%b done=%b want all zero",
                  bus.en, bus.grant, bus.sel, bus.busy, bus.slot_done);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.slot_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: grant=%b done=%b want 0001 0", bus.grant, bus.slot_done);
      end
      $display("test_reset_mid_slot done: grant=%b", bus.grant);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      rst     = 1'b1;
      bus.req = 4'b0000;
      test_reset();
      test_round_robin();
      test_sole_requester();
      test_early_release();
      test_rotation_skip();
      test_reset_mid_slot();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, want completion");
      $fatal(1, "timeout");
   end

endmodule
